wb_timer_irq: RTL and testbench
===============================

WB_TIMER_IRQ -- requirements
Module: wb_timer_irq

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16: prescaler register width in bits.
REQ-002 SHALL have parameter COMPARE_RST, default 32'hFFFF_FFFF: reset value of COMPARE.
REQ-003 SHALL have port i_clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port i_wb_cyc, input, 1: Wishbone cycle.
REQ-006 SHALL have port i_wb_stb, input, 1: Wishbone strobe.
REQ-007 SHALL have port i_wb_we, input, 1: write enable.
REQ-008 SHALL have port i_wb_addr, input, 32: byte address; only bits [4:2] decoded.
REQ-009 SHALL have port i_wb_data, input, 32: write data.
REQ-010 SHALL have port i_wb_sel, input, 4: byte lane enables.
REQ-011 SHALL have port o_wb_stall, output, 1: tied 0.
REQ-012 SHALL have port o_wb_ack, output, 1: transfer acknowledge.
REQ-013 SHALL have port o_wb_data, output, 32: read data.
REQ-014 SHALL have port o_irq, output, 1: level interrupt to the CPU IRQ vector.
REQ-015 SHALL have port i_eoi, input, 1: end-of-interrupt from the CPU; clears pending.

Function
REQ-016 Register map (offset): 0x00 CTRL {bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN}; 0x04 PRESCALE[PRESCALE_W-1:0]; 0x08 COUNT[31:0]; 0x0C COMPARE[31:0]; 0x10 STATUS {bit0 PENDING}, write-1-to-clear.
REQ-017 Access when i_wb_cyc & i_wb_stb; o_wb_ack SHALL assert exactly 1 cycle later, for 1 cycle; back-to-back strobes each acked.
REQ-018 Read data SHALL be registered with the ack; unmapped offsets (0x14-0x1C) read 0, writes ignored, still acked.
REQ-019 Writes SHALL update only byte lanes with i_wb_sel set; unimplemented bits read 0.
REQ-020 Prescaler: when EN=1, counter counts 0..PRESCALE then wraps, emitting a 1-cycle tick on wrap; PRESCALE=0 gives a tick every cycle; EN=0 holds prescaler at 0, no ticks.
REQ-021 On tick, if COUNT==COMPARE: PENDING<=1; AUTORELOAD=1 -> COUNT<=0; AUTORELOAD=0 -> COUNT holds, EN<=0 (one-shot).
REQ-022 On tick with COUNT!=COMPARE: COUNT<=COUNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0, no flag).
REQ-023 o_irq SHALL equal PENDING & IRQ_EN, registered-free combinational from flops, no extra latency.
REQ-024 PENDING cleared by i_eoi=1 or STATUS write with bit0=1 on lane 0.
REQ-025 Simultaneous set (match) and clear (eoi/W1C) in same cycle: set SHALL win.
REQ-026 Wishbone write to COUNT in a tick cycle: written value wins, no match evaluation that cycle, prescaler restarts at 0.
REQ-027 Write to PRESCALE or CTRL SHALL restart prescaler at 0.
REQ-028 Match of the written COUNT value is evaluated on the next tick only.

Reset
REQ-029 On i_rst=1, asynchronously: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=COMPARE_RST, PENDING=0, prescaler=0, o_wb_ack=0, o_wb_data=0, o_irq=0.
REQ-030 Reset mid-transfer SHALL drop the pending ack; first access after deassert is acked normally.

Structure
REQ-031 Register offsets, CTRL bit indices and STATUS bit index SHALL live in shared package wb_timer_pkg.
REQ-032 Prescaler SHALL be sub-module timer_prescaler (inputs en, restart, prescale; output tick).
REQ-033 Block SHALL attach to the peripheral arbiter port; no combinational path from i_wb_* to o_wb_*.

Verification
REQ-034 Reset -> read all regs: CTRL 0, PRESCALE 0, COUNT 0, COMPARE 0xFFFF_FFFF, STATUS 0, each acked 1 cycle after stb.
REQ-035 PRESCALE=3, COMPARE=5, CTRL=0x7 -> PENDING and o_irq rise 24 cycles after CTRL write; COUNT=0 next tick; repeats every 24 cycles.
REQ-036 One-shot: CTRL=0x5, COMPARE=2, PRESCALE=0 -> o_irq at 3rd tick, EN reads 0, COUNT stays 2.
REQ-037 COUNT=0xFFFF_FFFE, COMPARE=1, PRESCALE=0, EN -> COUNT wraps 0xFFFF_FFFF->0->1, PENDING set at tick after reaching 1, none at wrap.
REQ-038 i_eoi pulsed in the same cycle as a match -> PENDING stays 1; eoi next cycle -> o_irq 0.
REQ-039 Write COUNT=0x1234 with sel=4'b0001 over 0xAABBCCDD -> reads 0xAABBCC34; write to 0x18 -> acked, read 0.

Source files
------------

// File: rtl/wb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_pkg
// Purpose  : Register offsets, bit indices and byte-lane merge helper shared
//            by the Wishbone timer.
// Revision : 1.0 - initial release
// ============================================================================
package wb_timer_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COUNT    = 3'd2;
    localparam logic [2:0] ADDR_COMPARE  = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_W          = 3;
    localparam int STATUS_PENDING  = 0;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] apply_sel(
        input logic [31:0] cur,
        input logic [31:0] wdata,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_prescaler
// Purpose  : Counts 0..prescale while enabled and emits a one-cycle tick on wrap.
// Revision : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  w_wrap;

    assign w_wrap = (r_cnt == prescale);
    // A restart in the wrap cycle swallows that tick so the new phase starts clean.
    assign tick   = en & ~restart & w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || !en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRESCALE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_timer_irq.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_irq
// Purpose  : Wishbone-attached prescaled timer with compare match and level IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module wb_timer_irq #(
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_irq,
    input  logic        i_eoi
);
    import wb_timer_pkg::*;

    logic [CTRL_W-1:0]     r_ctrl;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_pending;
    logic                  r_ack;
    logic [31:0]           r_rdata;

    logic        w_access, w_wr;
    logic [2:0]  w_idx;
    logic [31:0] w_cur, w_wdata, w_prescale_ext;
    logic        w_ctrl_wr, w_prescale_wr, w_count_wr, w_compare_wr, w_status_wr;
    logic        w_tick, w_match, w_set, w_clr;
    logic        w_unused;

    assign w_access = i_wb_cyc & i_wb_stb;
    assign w_wr     = w_access & i_wb_we;
    assign w_idx    = i_wb_addr[4:2];
    assign w_unused = &{1'b0, i_wb_addr[31:5], i_wb_addr[1:0]};

    always_comb begin
        w_prescale_ext                   = '0;
        w_prescale_ext[PRESCALE_W-1:0]   = r_prescale;
    end

    // Current value of the addressed register, unimplemented bits as zero.
    always_comb begin
        w_cur = '0;
        case (w_idx)
            ADDR_CTRL:     w_cur[CTRL_W-1:0]     = r_ctrl;
            ADDR_PRESCALE: w_cur                 = w_prescale_ext;
            ADDR_COUNT:    w_cur                 = r_count;
            ADDR_COMPARE:  w_cur                 = r_compare;
            ADDR_STATUS:   w_cur[STATUS_PENDING] = r_pending;
            default:       w_cur                 = '0;
        endcase
    end

    assign w_wdata       = apply_sel(w_cur, i_wb_data, i_wb_sel);
    assign w_ctrl_wr     = w_wr & (w_idx == ADDR_CTRL);
    assign w_prescale_wr = w_wr & (w_idx == ADDR_PRESCALE);
    assign w_count_wr    = w_wr & (w_idx == ADDR_COUNT);
    assign w_compare_wr  = w_wr & (w_idx == ADDR_COMPARE);
    assign w_status_wr   = w_wr & (w_idx == ADDR_STATUS);

    assign w_match = (r_count == r_compare);
    assign w_set   = w_tick & w_match & ~w_count_wr;
    assign w_clr   = i_eoi | (w_status_wr & i_wb_sel[0] & i_wb_data[STATUS_PENDING]);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (i_clk),
        .rst      (i_rst),
        .en       (r_ctrl[CTRL_EN]),
        .restart  (w_ctrl_wr | w_prescale_wr | w_count_wr),
        .prescale (r_prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_count    <= '0;
            r_compare  <= COMPARE_RST;
            r_pending  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= w_wdata[CTRL_W-1:0];
            end else if (w_set && !r_ctrl[CTRL_AUTORELOAD]) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end

            if (w_prescale_wr) r_prescale <= w_wdata[PRESCALE_W-1:0];
            if (w_compare_wr)  r_compare  <= w_wdata;

            if (w_count_wr) begin
                r_count <= w_wdata;
            end else if (w_tick) begin
                if (!w_match) begin
                    r_count <= r_count + 32'd1;
                end else if (r_ctrl[CTRL_AUTORELOAD]) begin
                    r_count <= '0;
                end
            end

            // Match set takes priority over any clear in the same cycle.
            if (w_set) begin
                r_pending <= 1'b1;
            end else if (w_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_access;
            r_rdata <= (w_access & ~i_wb_we) ? w_cur : '0;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_irq      = r_pending & r_ctrl[CTRL_IRQ_EN];

endmodule
`default_nettype wire

// File: tb/tb_wb_timer_irq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_timer_irq
// Purpose  : Self-checking bench for wb_timer_irq with a closed-form timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_timer_irq;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_PRESCALE = 32'h04;
    localparam logic [31:0] A_COUNT    = 32'h08;
    localparam logic [31:0] A_COMPARE  = 32'h0C;
    localparam logic [31:0] A_STATUS   = 32'h10;
    localparam logic [31:0] A_HOLE     = 32'h18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_addr = '0, wb_wdata = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_stall, wb_ack, irq;
    logic [31:0] wb_rdata;
    logic        eoi = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_timer_irq #(.PRESCALE_W(16), .COMPARE_RST(32'hFFFF_FFFF)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wb_cyc   (wb_cyc),
        .i_wb_stb   (wb_stb),
        .i_wb_we    (wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_wdata),
        .i_wb_sel   (wb_sel),
        .o_wb_stall (wb_stall),
        .o_wb_ack   (wb_ack),
        .o_wb_data  (wb_rdata),
        .o_irq      (irq),
        .i_eoi      (eoi)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks enter and leave 1ns after a rising edge.
    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = a; wb_wdata = d; wb_sel = s;
        step(1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check_val("wr_ack", {31'b0, wb_ack}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_addr = a; wb_sel = 4'hF;
        step(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check_val({tag, "_ack"}, {31'b0, wb_ack}, 32'd1);
        check_val(tag, wb_rdata, exp);
    endtask

    // Match lands on tick number (COMPARE-COUNT)+1, each tick PRESCALE+1 cycles apart.
    task automatic run_trial(input int p, input logic [31:0] c0, input logic [31:0] m, input bit ar);
        logic [31:0] d;
        int n_cyc, t_reload;
        wb_write(A_CTRL, 32'h0, 4'hF);
        wb_write(A_STATUS, 32'h1, 4'hF);
        wb_write(A_PRESCALE, 32'(p), 4'hF);
        wb_write(A_COMPARE, m, 4'hF);
        wb_write(A_COUNT, c0, 4'hF);
        d = m - c0;
        n_cyc = (int'(d) + 1) * (p + 1);
        wb_write(A_CTRL, {29'b0, 1'b1, ar, 1'b1}, 4'hF);
        step(n_cyc - 1);
        check_val("irq_before_match", {31'b0, irq}, 32'd0);
        step(1);
        check_val("irq_at_match", {31'b0, irq}, 32'd1);
        if (!ar) begin
            read_check("oneshot_ctrl", A_CTRL, 32'h4);
            read_check("oneshot_count", A_COUNT, m);
            read_check("oneshot_status", A_STATUS, 32'h1);
            step(2 * (p + 1) + 2);
            read_check("oneshot_hold", A_COUNT, m);
        end else begin
            t_reload = (int'(m) + 1) * (p + 1);
            eoi = 1'b1;
            step(1);
            eoi = 1'b0;
            check_val("eoi_clear", {31'b0, irq}, 32'd0);
            read_check("reload_count", A_COUNT, 32'(1 / (p + 1)));
            step(t_reload - 3);
            check_val("irq_before_rematch", {31'b0, irq}, 32'd0);
            step(1);
            check_val("irq_rematch", {31'b0, irq}, 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] c0, m;
        int p;
        bit ar;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack", {31'b0, wb_ack}, 32'd0);
        check_val("rst_rdata", wb_rdata, 32'd0);
        check_val("rst_irq", {31'b0, irq}, 32'd0);
        check_val("stall", {31'b0, wb_stall}, 32'd0);
        rst = 1'b0;
        step(1);

        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_prescale", A_PRESCALE, 32'h0);
        read_check("rst_count", A_COUNT, 32'h0);
        read_check("rst_compare", A_COMPARE, 32'hFFFF_FFFF);
        read_check("rst_status", A_STATUS, 32'h0);
        step(1);
        check_val("ack_one_cycle", {31'b0, wb_ack}, 32'd0);

        // Byte lanes, unimplemented bits and the unmapped hole.
        wb_write(A_COUNT, 32'hAABB_CCDD, 4'hF);
        wb_write(A_COUNT, 32'h0000_1234, 4'b0001);
        read_check("lane0_count", A_COUNT, 32'hAABB_CC34);
        wb_write(A_HOLE, 32'hDEAD_BEEF, 4'hF);
        read_check("hole_read", A_HOLE, 32'h0);
        wb_write(A_PRESCALE, 32'hFFFF_FFFF, 4'hF);
        read_check("prescale_width", A_PRESCALE, 32'h0000_FFFF);
        wb_write(A_CTRL, 32'hFFFF_FFF8, 4'hF);
        read_check("ctrl_unimpl", A_CTRL, 32'h0);
        wb_write(A_CTRL, 32'h7, 4'h0);
        read_check("ctrl_sel0", A_CTRL, 32'h0);

        run_trial(3, 32'h0, 32'h5, 1'b1);
        run_trial(0, 32'h0, 32'h2, 1'b0);
        run_trial(0, 32'hFFFF_FFFE, 32'h1, 1'b0);

        // EOI coinciding with the match edge loses; the following one clears.
        wb_write(A_CTRL, 32'h0, 4'hF);
        wb_write(A_STATUS, 32'h1, 4'hF);
        wb_write(A_PRESCALE, 32'h0, 4'hF);
        wb_write(A_COMPARE, 32'h3, 4'hF);
        wb_write(A_COUNT, 32'h0, 4'hF);
        wb_write(A_CTRL, 32'h5, 4'hF);
        step(3);
        check_val("eoi_pre", {31'b0, irq}, 32'd0);
        eoi = 1'b1;
        step(1);
        check_val("eoi_vs_set", {31'b0, irq}, 32'd1);
        step(1);
        eoi = 1'b0;
        check_val("eoi_after", {31'b0, irq}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            p  = int'($urandom_range(0, 4));
            ar = 1'($urandom_range(0, 1));
            if (ar) begin
                c0 = $urandom_range(0, 3);
                m  = c0 + $urandom_range(0, 5);
                if (m < 2) m = 2;
            end else begin
                c0 = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
                m  = c0 + $urandom_range(0, 5);
            end
            run_trial(p, c0, m, ar);
        end

        // Asynchronous reset while an ack is in flight, with IRQ asserted.
        wb_write(A_COMPARE, 32'h55, 4'hF);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = A_COMPARE; wb_sel = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("midrst_ack", {31'b0, wb_ack}, 32'd0);
        check_val("midrst_rdata", wb_rdata, 32'd0);
        check_val("midrst_irq", {31'b0, irq}, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);
        read_check("postrst_compare", A_COMPARE, 32'hFFFF_FFFF);
        read_check("postrst_status", A_STATUS, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
